// File: rtl/pc_unit_if.sv
// Decoder/datapath-facing bundle for the program-counter stage.
// The slave side belongs to pc_unit. The master side belongs to the decoder and datapath.
interface pc_unit_if;
  logic [2:0]  PCSrc;
  logic        BranchTaken;
  logic [31:0] Imm32;
  logic [25:0] JT;
  logic [31:0] DatabusA;
  logic        Stall;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        IntTaken;
  logic [31:0] RetPC;

  modport slave (
    input  PCSrc, BranchTaken, Imm32, JT, DatabusA, Stall,
    output PC, PCPlus4, IntTaken, RetPC
  );

  modport master (
    output PCSrc, BranchTaken, Imm32, JT, DatabusA, Stall,
    input  PC, PCPlus4, IntTaken, RetPC
  );
endinterface

// File: rtl/pc_unit.sv
// Program-counter stage: PC register, next-PC select, IRQ synchroniser and interrupt arbitration.
// Optional build macro PC_UNIT_ALIGN_CHECK_EN: a misaligned register jump goes to the exception vector.
module pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] ILLOP_PC = 32'h8000_0004,
  parameter logic [31:0] XADR_PC  = 32'h8000_0008
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       IRQ,
  pc_unit_if.slave   bus
);

  logic [31:0] pc;
  logic [31:0] next_pc;
  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] jr_target;
  logic        irq_s1;
  logic        irq_s2;
  logic        int_taken;
  logic        unused_imm_bits;

  // Bit 31 is the kernel flag, so every add runs on 31 bits and must never carry into it
  assign pc_plus4      = {pc[31], pc[30:0] + 31'd4};
  assign branch_target = {pc[31], pc_plus4[30:0] + {bus.Imm32[28:0], 2'b00}};
  assign jump_target   = {pc_plus4[31:28], bus.JT, 2'b00};
  assign jr_target     = {pc[31] & bus.DatabusA[31], bus.DatabusA[30:0]};
  assign unused_imm_bits = ^bus.Imm32[31:29];

  // Interrupts are masked in kernel mode and while stalled
  assign int_taken = irq_s2 & ~pc[31] & ~bus.Stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_s1 <= 1'b0;
      irq_s2 <= 1'b0;
    end else begin
      irq_s1 <= IRQ;
      irq_s2 <= irq_s1;
    end
  end

  always_comb begin
    next_pc = pc;
    if (bus.Stall) begin
      next_pc = pc;
    end else if (int_taken) begin
      next_pc = ILLOP_PC;
    end else begin
      case (bus.PCSrc)
        3'b000:  next_pc = pc_plus4;
        3'b001:  next_pc = bus.BranchTaken ? branch_target : pc_plus4;
        3'b010:  next_pc = jump_target;
`ifdef PC_UNIT_ALIGN_CHECK_EN
        3'b011:  next_pc = (bus.DatabusA[1:0] != 2'b00) ? XADR_PC : jr_target;
`else
        3'b011:  next_pc = jr_target;
`endif
        3'b100:  next_pc = ILLOP_PC;
        default: next_pc = XADR_PC;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else begin
      pc <= next_pc;
    end
  end

  // A preempted instruction restarts on return, so the link is the current PC
  assign bus.PC       = pc;
  assign bus.PCPlus4  = pc_plus4;
  assign bus.IntTaken = int_taken;
  assign bus.RetPC    = int_taken ? pc : pc_plus4;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit.
// Works with PC_UNIT_ALIGN_CHECK_EN either defined or left undefined.
module tb_pc_unit;

  logic clk;
  logic reset;
  logic IRQ;
  int   checks;
  int   failures;
  logic [31:0] exp_align;

  pc_unit_if bus();

  pc_unit dut (
    .clk   (clk),
    .reset (reset),
    .IRQ   (IRQ),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [2:0] src, input logic bt, input logic [31:0] imm,
                               input logic [25:0] jt, input logic [31:0] dba, input logic stall);
    bus.PCSrc       = src;
    bus.BranchTaken = bt;
    bus.Imm32       = imm;
    bus.JT          = jt;
    bus.DatabusA    = dba;
    bus.Stall       = stall;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // A kernel jr loads an arbitrary PC, including one with bit 31 set
  task automatic jumpTo(input logic [31:0] target);
    applyStimulus(3'b011, 1'b0, 32'h0, 26'h0, target, 1'b0);
    step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    IRQ      = 1'b0;
    applyStimulus(3'b000, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_pc", bus.PC, 32'h8000_0000);
    checkOutput("reset_pcplus4", bus.PCPlus4, 32'h8000_0004);
    checkOutput("reset_retpc", bus.RetPC, 32'h8000_0004);
    checkOutput("reset_inttaken", {31'b0, bus.IntTaken}, 32'h0);
    reset = 1'b0;
    repeat (3) step();
    checkOutput("seq_3_edges", bus.PC, 32'h8000_000C);

    step();
    #2 reset = 1'b1;
    #1;
    checkOutput("async_reset_mid", bus.PC, 32'h8000_0000);
    reset = 1'b0;
    repeat (3) step();
    checkOutput("seq_after_reset", bus.PC, 32'h8000_000C);

    jumpTo(32'h0000_0100);
    checkOutput("jr_to_0100", bus.PC, 32'h0000_0100);
    checkOutput("pcplus4_0100", bus.PCPlus4, 32'h0000_0104);
    applyStimulus(3'b001, 1'b1, 32'hFFFF_FFFE, 26'h0, 32'h0, 1'b0);
    step();
    checkOutput("branch_taken", bus.PC, 32'h0000_00FC);
    jumpTo(32'h0000_0100);
    applyStimulus(3'b001, 1'b0, 32'hFFFF_FFFE, 26'h0, 32'h0, 1'b0);
    step();
    checkOutput("branch_not_taken", bus.PC, 32'h0000_0104);
    jumpTo(32'h0000_0100);
    applyStimulus(3'b010, 1'b0, 32'h0, 26'h000_0040, 32'h0, 1'b0);
    step();
    checkOutput("jump", bus.PC, 32'h0000_0100);

    jumpTo(32'h0000_0200);
    jumpTo(32'h8000_0300);
    checkOutput("jr_user_no_kernel", bus.PC, 32'h0000_0300);
    applyStimulus(3'b101, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0);
    #1;
    checkOutput("xadr_retpc", bus.RetPC, 32'h0000_0304);
    checkOutput("xadr_no_int", {31'b0, bus.IntTaken}, 32'h0);
    step();
    checkOutput("xadr_vector", bus.PC, 32'h8000_0008);
    jumpTo(32'h8000_0010);
    checkOutput("jr_kernel_stay", bus.PC, 32'h8000_0010);
    jumpTo(32'h0000_0400);
    checkOutput("jr_kernel_to_user", bus.PC, 32'h0000_0400);

    jumpTo(32'h7FFF_FFFC);
    applyStimulus(3'b000, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0);
    step();
    checkOutput("wrap_user", bus.PC, 32'h0000_0000);
    applyStimulus(3'b101, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0);
    step();
    jumpTo(32'hFFFF_FFFC);
    checkOutput("wrap_kernel_pcplus4", bus.PCPlus4, 32'h8000_0000);
    applyStimulus(3'b000, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0);
    step();
    checkOutput("wrap_kernel", bus.PC, 32'h8000_0000);

    // PC held at 0x40 by a repeated jr while the request crosses the synchroniser
    jumpTo(32'h0000_0040);
    IRQ = 1'b1;
    step();
    checkOutput("irq_edge1_no_int", {31'b0, bus.IntTaken}, 32'h0);
    step();
    checkOutput("irq_edge2_int", {31'b0, bus.IntTaken}, 32'h1);
    checkOutput("irq_retpc", bus.RetPC, 32'h0000_0040);
    step();
    checkOutput("irq_vector", bus.PC, 32'h8000_0004);
    checkOutput("irq_one_cycle", {31'b0, bus.IntTaken}, 32'h0);
    jumpTo(32'h8000_0020);
    checkOutput("kernel_masked", {31'b0, bus.IntTaken}, 32'h0);

    jumpTo(32'h0000_0040);
    bus.Stall = 1'b1;
    #1;
    checkOutput("stall_masks_int", {31'b0, bus.IntTaken}, 32'h0);
    step();
    step();
    checkOutput("stall_holds_pc", bus.PC, 32'h0000_0040);
    checkOutput("stall_pcplus4", bus.PCPlus4, 32'h0000_0044);
    bus.Stall = 1'b0;
    #1;
    checkOutput("stall_release_int", {31'b0, bus.IntTaken}, 32'h1);
    step();
    checkOutput("stall_release_vector", bus.PC, 32'h8000_0004);

    jumpTo(32'h0000_0040);
    applyStimulus(3'b101, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0);
    #1;
    checkOutput("collide_int", {31'b0, bus.IntTaken}, 32'h1);
    checkOutput("collide_retpc", bus.RetPC, 32'h0000_0040);
    step();
    checkOutput("collide_vector", bus.PC, 32'h8000_0004);

    IRQ = 1'b0;
    applyStimulus(3'b000, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0);
    repeat (2) step();
    jumpTo(32'h0000_0300);
    checkOutput("irq_cleared", {31'b0, bus.IntTaken}, 32'h0);
`ifdef PC_UNIT_ALIGN_CHECK_EN
    exp_align = 32'h8000_0008;
`else
    exp_align = 32'h0000_0102;
`endif
    jumpTo(32'h0000_0102);
    checkOutput("jr_misaligned", bus.PC, exp_align);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
